// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: measures line/frame geometry from hs_n/vs_n/blank_n,
// recovers active-pixel coordinates, flags sticky timing errors and declares lock.
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hs_n,
  input  logic        vs_n,
  input  logic        blank_n,
  input  logic        err_clr,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_valid,
  output logic        line_err,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  localparam logic [10:0] H_TOTAL_C  = 11'(H_TOTAL);
  localparam logic [10:0] H_SYNC_C   = 11'(H_SYNC);
  localparam logic [10:0] H_ACTIVE_C = 11'(H_ACTIVE);
  localparam logic [10:0] V_TOTAL_C  = 11'(V_TOTAL);
  localparam logic [10:0] V_ACTIVE_C = 11'(V_ACTIVE);
  localparam logic [10:0] H_TMO      = 11'(2 * H_TOTAL);
  localparam logic [10:0] V_TMO_M1   = 11'(2 * V_TOTAL - 1);
  localparam logic [2:0]  LOCK_C     = 3'(LOCK_FRAMES);

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7ff) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction

  logic        hs_prev, vs_prev, blank_prev;
  logic [10:0] h_cnt, hs_w, run_cnt, v_cnt, a_cnt;
  logic        h_seen, v_seen, frame_bad;
  logic [2:0]  good_cnt;

  logic        hs_fall, hs_rise, vs_fall, blank_fall, blank_rise;
  logic        h_tmo, h_err, v_tmo, v_mis, frame_good, fe_set;
  logic [10:0] v_close, a_close;
  logic [2:0]  good_next;

  always_comb begin
    hs_fall    = hs_prev & ~hs_n;
    hs_rise    = ~hs_prev & hs_n;
    vs_fall    = vs_prev & ~vs_n;
    blank_fall = blank_prev & ~blank_n;
    blank_rise = ~blank_prev & blank_n;
    h_tmo      = ~hs_fall & (h_cnt == H_TMO);
    // Measurements are only trusted once an hs fall has anchored the line.
    h_err      = h_tmo | (h_seen & ((hs_fall & ((h_cnt + 11'd1) != H_TOTAL_C)) |
                                    (hs_rise & (hs_w != H_SYNC_C)) |
                                    (blank_fall & (run_cnt != H_ACTIVE_C))));
    // Edges coincident with the vs fall belong to the frame being closed.
    v_close    = v_cnt + {10'd0, hs_fall};
    a_close    = a_cnt + {10'd0, blank_fall};
    v_mis      = (v_close != V_TOTAL_C) | (a_close != V_ACTIVE_C);
    frame_good = ~v_mis & ~frame_bad & ~h_err;
    v_tmo      = hs_fall & ~vs_fall & (v_cnt == V_TMO_M1);
    fe_set     = (vs_fall & v_seen & v_mis) | v_tmo;
    good_next  = (good_cnt == LOCK_C) ? LOCK_C : good_cnt + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      blank_prev  <= 1'b0;
      h_cnt       <= '0;
      hs_w        <= '0;
      run_cnt     <= '0;
      v_cnt       <= '0;
      a_cnt       <= '0;
      h_seen      <= 1'b0;
      v_seen      <= 1'b0;
      frame_bad   <= 1'b0;
      good_cnt    <= '0;
      locked      <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_valid   <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      hs_prev    <= hs_n;
      vs_prev    <= vs_n;
      blank_prev <= blank_n;

      h_cnt <= hs_fall ? 11'd0 : sat_inc11(h_cnt);
      if (hs_fall)         hs_w <= 11'd1;
      else if (!hs_n)      hs_w <= sat_inc11(hs_w);
      if (blank_rise)      run_cnt <= 11'd1;
      else if (blank_n)    run_cnt <= sat_inc11(run_cnt);

      if (hs_fall && h_seen) line_len <= h_cnt + 11'd1;
      if (h_tmo)             h_seen <= 1'b0;
      else if (hs_fall)      h_seen <= 1'b1;

      if (vs_fall) begin
        v_cnt     <= '0;
        a_cnt     <= '0;
        frame_bad <= 1'b0;
        v_seen    <= 1'b1;
        if (v_seen) begin
          frame_lines <= v_close;
          if (frame_good) begin
            good_cnt  <= good_next;
            frame_cnt <= frame_cnt + 16'd1;
            locked    <= (good_next == LOCK_C);
          end else begin
            good_cnt <= '0;
            locked   <= 1'b0;
          end
        end
      end else begin
        if (hs_fall)    v_cnt <= sat_inc11(v_cnt);
        if (blank_fall) a_cnt <= sat_inc11(a_cnt);
        if (h_err)      frame_bad <= 1'b1;
        if (v_tmo) begin
          v_seen   <= 1'b0;
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      end
      if (h_tmo) locked <= 1'b0;

      // A newly detected error outranks a simultaneous clear.
      if (h_err)        line_err <= 1'b1;
      else if (err_clr) line_err <= 1'b0;
      if (fe_set)       frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;

      pix_valid <= blank_n;
      if (blank_rise)   pix_x <= '0;
      else if (blank_n) pix_x <= sat_inc10(pix_x);
      if (vs_fall)         pix_y <= '0;
      else if (blank_fall) pix_y <= sat_inc10(pix_y);
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor on a reduced 40x20 raster: scenario table, hand corner cases,
// randomized frames, all checked cycle by cycle against a timestamp-based reference model.
module tb_vga_sync_monitor;
  localparam int HT = 40, HS = 6, HA = 24, VT = 20, VA = 12, LK = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, hs_n, vs_n, blank_n, err_clr;
  logic        locked, pix_valid, line_err, frame_err;
  logic [10:0] line_len, frame_lines;
  logic [9:0]  pix_x, pix_y;
  logic [15:0] frame_cnt;

  vga_sync_monitor #(.H_TOTAL(HT), .H_SYNC(HS), .H_ACTIVE(HA), .V_TOTAL(VT),
                     .V_ACTIVE(VA), .LOCK_FRAMES(LK)) dut (
    .clk(clk), .reset(reset), .hs_n(hs_n), .vs_n(vs_n), .blank_n(blank_n),
    .err_clr(err_clr), .locked(locked), .line_len(line_len), .frame_lines(frame_lines),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .line_err(line_err),
    .frame_err(frame_err), .frame_cnt(frame_cnt));

  int checks = 0, errors = 0, now = 0;

  // Reference model state: event timestamps instead of counters.
  int m_hs_p, m_vs_p, m_bl_p, t_h, t_hl, t_br;
  int m_hseen, m_vseen, m_lines, m_act, m_fbad, m_good;
  int e_locked, e_ll, e_fl, e_x, e_y, e_pv, e_le, e_fe, e_fc;

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input logic r, input logic hs, input logic vs,
                            input logic bl, input logic clr);
    int hcnt, closing, acts;
    bit hf, hr, vf, bf, br, herr, htmo, fes, goodf;
    if (r) begin
      m_hs_p = 1; m_vs_p = 1; m_bl_p = 0; t_h = now; t_hl = now; t_br = now;
      m_hseen = 0; m_vseen = 0; m_lines = 0; m_act = 0; m_fbad = 0; m_good = 0;
      e_locked = 0; e_ll = 0; e_fl = 0; e_x = 0; e_y = 0; e_pv = 0;
      e_le = 0; e_fe = 0; e_fc = 0;
      return;
    end
    hcnt = mn(now - t_h - 1, 2047);
    hf = m_hs_p && !hs;  hr = !m_hs_p && hs;  vf = m_vs_p && !vs;
    bf = m_bl_p && !bl;  br = !m_bl_p && bl;
    htmo = !hf && (hcnt == 2 * HT);
    herr = htmo || (m_hseen && ((hf && (hcnt + 1) != HT) ||
                                (hr && mn(now - t_hl, 2047) != HS) ||
                                (bf && mn(now - t_br, 2047) != HA)));
    fes = 0;
    if (hf && m_hseen) e_ll = (hcnt + 1) % 2048;
    if (vf) begin
      if (m_vseen) begin
        closing = m_lines + int'(hf);
        acts    = m_act + int'(bf);
        e_fl    = closing % 2048;
        goodf   = (closing == VT) && (acts == VA) && !m_fbad && !herr;
        if (goodf) begin
          m_good = mn(m_good + 1, LK);
          e_fc = (e_fc + 1) % 65536;
          e_locked = (m_good == LK);
        end else begin
          m_good = 0; e_locked = 0;
          fes = (closing != VT) || (acts != VA);
        end
      end
      m_vseen = 1; m_lines = 0; m_act = 0; m_fbad = 0;
    end else begin
      m_lines = mn(m_lines + int'(hf), 2047);
      m_act   = mn(m_act + int'(bf), 2047);
      if (herr) m_fbad = 1;
      if (hf && m_lines == 2 * VT) begin
        fes = 1; e_locked = 0; m_vseen = 0; m_good = 0;
      end
    end
    if (htmo) begin e_locked = 0; m_hseen = 0; end
    else if (hf) m_hseen = 1;
    if (herr) e_le = 1; else if (clr) e_le = 0;
    if (fes)  e_fe = 1; else if (clr) e_fe = 0;
    if (br) t_br = now;
    if (bl) e_x = mn(now - t_br, 1023);
    if (vf) e_y = 0; else if (bf) e_y = mn(e_y + 1, 1023);
    e_pv = bl;
    if (hf) begin t_h = now; t_hl = now; end
    m_hs_p = hs; m_vs_p = vs; m_bl_p = bl;
  endtask

  function automatic logic [61:0] dut_pack();
    return {locked, line_len, frame_lines, pix_x, pix_y, pix_valid, line_err, frame_err, frame_cnt};
  endfunction

  function automatic logic [61:0] model_pack();
    return {1'(e_locked), 11'(e_ll), 11'(e_fl), 10'(e_x), 10'(e_y), 1'(e_pv),
            1'(e_le), 1'(e_fe), 16'(e_fc)};
  endfunction

  task automatic chk_vec(input string name, input logic [61:0] act, input logic [61:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: dut %h expected %h", name, now, act, exp);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic r, input logic hs, input logic vs,
                      input logic bl, input logic clr);
    reset = r; hs_n = hs; vs_n = vs; blank_n = bl; err_clr = clr;
    @(posedge clk);
    model_step(r, hs, vs, bl, clr);
    now++;
    #1;
    chk_vec("cycle", dut_pack(), model_pack());
  endtask

  // kind: 0 nominal, 1 line+1, 2 line-1, 3 hsync+1, 4 active-1 (applied to line 'bad').
  task automatic run_frame(input int kind, input int bad, input int vt, input int from,
                           input int upto, input int clr_at, input int rst_at, input bit rclr);
    int k, len, hsw, ha;
    logic hs, vs, bl, c;
    k = 0;
    for (int l = 0; l < vt; l++) begin
      len = HT; hsw = HS; ha = HA;
      if (l == bad) begin
        case (kind)
          1: len = HT + 1;
          2: len = HT - 1;
          3: hsw = HS + 1;
          4: ha  = HA - 1;
          default: ;
        endcase
      end
      for (int p = 0; p < len; p++) begin
        if (k >= from && k < upto) begin
          hs = !(p < hsw);
          vs = !(l < 2);
          bl = (l >= 5) && (l < 5 + VA) && (p >= 10) && (p < 10 + ha);
          c  = (k == clr_at) || (rclr && $urandom_range(0, 63) == 0);
          tick(k == rst_at, hs, vs, bl, c);
          if (k == rst_at) chk_vec("reset_mid", dut_pack(), 62'd0);
        end
        k++;
      end
    end
  endtask

  typedef struct {
    int nfr, kind, bad, vt, clr_at, pre;
    int x_locked, x_ll, x_fl, x_le, x_fe, x_fc;
  } scen_t;

  scen_t sc[7];
  int    from, kind, vt, bad;

  initial begin
    //        nfr kind bad vt  clr pre | lock ll  fl le fe fc
    sc[0] = '{2, 0, -1, 20, -1, 0,  1, 40, 20, 0, 0, 2};
    sc[1] = '{1, 1,  7, 20, -1, 0,  0, 40, 20, 1, 0, 2};
    sc[2] = '{2, 0, -1, 20, -1, 0,  1, 40, 20, 1, 0, 4};
    sc[3] = '{1, 0, -1, 19,  3, 0,  0, 40, 19, 0, 1, 4};
    sc[4] = '{2, 0, -1, 20, -1, 0,  1, 40, 20, 0, 1, 6};
    sc[5] = '{3, 0, -1, 20, -1, 1,  1, 40, 20, 0, 1, 9};
    sc[6] = '{2, 0, -1, 20, -1, 2,  1, 40, 20, 0, 0, 2};

    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_vec("reset_state", dut_pack(), 62'd0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      if (sc[i].pre == 1) begin
        // hs_n stuck high past the timeout, with err_clr racing the new error
        for (int k = 1; k <= 82; k++) begin
          tick(1'b0, 1'b1, 1'b1, 1'b0, (k == 1) || (k >= 81));
          if (k == 81) begin
            chk("tmo_line_err", int'(line_err), 1);
            chk("tmo_locked", int'(locked), 0);
          end
          if (k == 82) chk("clr_after_tmo", int'(line_err), 0);
        end
      end
      if (sc[i].pre == 2) run_frame(0, -1, VT, 1, 1 << 20, -1, 300, 1'b0);
      from = (i == 0 || sc[i].pre != 0) ? 0 : 1;
      for (int f = 0; f < sc[i].nfr; f++)
        run_frame(sc[i].kind, sc[i].bad, sc[i].vt, (f == 0) ? from : 0, 1 << 20,
                  (f == 0) ? sc[i].clr_at : -1, -1, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("s%0d_locked", i),      int'(locked),      sc[i].x_locked);
      chk($sformatf("s%0d_line_len", i),    int'(line_len),    sc[i].x_ll);
      chk($sformatf("s%0d_frame_lines", i), int'(frame_lines), sc[i].x_fl);
      chk($sformatf("s%0d_line_err", i),    int'(line_err),    sc[i].x_le);
      chk($sformatf("s%0d_frame_err", i),   int'(frame_err),   sc[i].x_fe);
      chk($sformatf("s%0d_frame_cnt", i),   int'(frame_cnt),   sc[i].x_fc);
    end

    for (int f = 0; f < 8; f++) begin
      kind = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
      vt   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(19, 21)) : VT;
      bad  = (kind == 4) ? int'($urandom_range(5, 16)) : int'($urandom_range(1, vt - 1));
      run_frame(kind, bad, vt, (f == 0) ? 1 : 0, 1 << 20, -1, -1, 1'b1);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
